// File: rtl/memory_loader_if.sv
// Loader bus: session control, byte stream in, memory write port and status out.
interface memory_loader_if #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned WORD_WIDTH    = 32
);
  logic                     start;
  logic                     memory_select;
  logic [ADDRESS_WIDTH:0]   word_count;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     write_enable;
  logic                     write_target;
  logic [31:0]              write_address;
  logic [WORD_WIDTH-1:0]    write_data;
  logic                     processor_hold;
  logic                     busy;
  logic                     done;
  logic [WORD_WIDTH-1:0]    checksum;

  // Host / stream source side
  modport master (
    output start, memory_select, word_count, byte_valid, byte_data,
    input  byte_ready, write_enable, write_target, write_address, write_data,
           processor_hold, busy, done, checksum
  );

  // Loader side
  modport slave (
    input  start, memory_select, word_count, byte_valid, byte_data,
    output byte_ready, write_enable, write_target, write_address, write_data,
           processor_hold, busy, done, checksum
  );
endinterface

// File: rtl/memory_loader.sv
// Byte-stream memory loader: packs little-endian bytes into words, writes them to
// sequential addresses, holds the processor while loading and keeps a checksum.
module memory_loader #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned WORD_WIDTH    = 32
) (
  input  logic           clock,
  input  logic           reset,
  memory_loader_if.slave bus
);
  localparam int unsigned COUNT_WIDTH = ADDRESS_WIDTH + 1;
  localparam int unsigned BUF_WIDTH   = WORD_WIDTH - 8;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  state_t                 state, state_d;
  logic                   target, target_d;
  logic [COUNT_WIDTH-1:0] count, count_d;
  logic [COUNT_WIDTH-1:0] word_index, word_index_d;
  logic [1:0]             byte_index, byte_index_d;
  logic [BUF_WIDTH-1:0]   word_buf, word_buf_d;
  logic                   write_target_d;
  logic [31:0]            write_address_d;
  logic [WORD_WIDTH-1:0]  write_data_d;
  logic [WORD_WIDTH-1:0]  checksum_d;
  logic [WORD_WIDTH-1:0]  word_c;
  logic                   accept_c;

  // The three earlier bytes sit in word_buf; the current byte completes the word.
  assign word_c   = {bus.byte_data, word_buf};
  assign accept_c = bus.byte_valid & bus.byte_ready;

  // Next-state and next-register values
  always_comb begin
    state_d         = state;
    target_d        = target;
    count_d         = count;
    word_index_d    = word_index;
    byte_index_d    = byte_index;
    word_buf_d      = word_buf;
    write_target_d  = bus.write_target;
    write_address_d = bus.write_address;
    write_data_d    = bus.write_data;
    checksum_d      = bus.checksum;
    case (state)
      IDLE: begin
        if (bus.start) begin
          target_d     = bus.memory_select;
          count_d      = bus.word_count;
          word_index_d = '0;
          byte_index_d = '0;
          checksum_d   = '0;
          state_d      = (bus.word_count == '0) ? FINISH : COLLECT;
        end
      end
      COLLECT: begin
        if (accept_c) begin
          byte_index_d = byte_index + 2'd1;
          // Shift right so the first byte ends up in the low lane
          word_buf_d   = {bus.byte_data, word_buf[BUF_WIDTH-1:8]};
          if (byte_index == 2'd3) begin
            write_target_d  = target;
            write_address_d = 32'({word_index[ADDRESS_WIDTH-1:0], 2'b00});
            write_data_d    = word_c;
            checksum_d      = bus.checksum + word_c;
            word_index_d    = word_index + COUNT_WIDTH'(1);
            state_d         = WRITE;
          end
        end
      end
      WRITE:   state_d = (word_index == count) ? FINISH : COLLECT;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; status flags are decoded from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      target             <= 1'b0;
      count              <= '0;
      word_index         <= '0;
      byte_index         <= '0;
      word_buf           <= '0;
      bus.byte_ready     <= 1'b0;
      bus.write_enable   <= 1'b0;
      bus.write_target   <= 1'b0;
      bus.write_address  <= '0;
      bus.write_data     <= '0;
      bus.processor_hold <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.checksum       <= '0;
    end else begin
      state              <= state_d;
      target             <= target_d;
      count              <= count_d;
      word_index         <= word_index_d;
      byte_index         <= byte_index_d;
      word_buf           <= word_buf_d;
      bus.byte_ready     <= (state_d == COLLECT);
      bus.write_enable   <= (state_d == WRITE);
      bus.write_target   <= write_target_d;
      bus.write_address  <= write_address_d;
      bus.write_data     <= write_data_d;
      bus.processor_hold <= (state_d == COLLECT) || (state_d == WRITE);
      bus.busy           <= (state_d == COLLECT) || (state_d == WRITE);
      bus.done           <= (state_d == FINISH);
      bus.checksum       <= checksum_d;
    end
  end
endmodule

// File: doc/memory_loader.md
# memory_loader

Byte-stream program/data loader that fills the computer's instruction or data memory before a run. It assembles incoming bytes into 32-bit words, writes each completed word to sequential memory addresses, and holds the processor in reset while loading. It is the write-side counterpart of the memory display read ports, sits beside the memories in the computer top level, and reports a running checksum.

## Interface

**Parameters**
- ADDRESS_WIDTH, 6: word-address width; memory depth is 2^ADDRESS_WIDTH words.
- WORD_WIDTH, 32: memory word width; fixed at 4 bytes.

**Ports**
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load session; sampled only in IDLE.
- memory_select  input  1  load target: 0 = instruction memory, 1 = data memory; latched on accepted start.
- word_count  input  ADDRESS_WIDTH+1  number of words to load, 0..2^ADDRESS_WIDTH; latched on accepted start.
- byte_valid  input  1  byte_data holds a byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- write_enable  output  1  one-cycle memory write strobe.
- write_target  output  1  latched memory_select.
- write_address  output  32  byte address, {zeros, word_index, 2'b00}.
- write_data  output  32  assembled word.
- processor_hold  output  1  keeps the processor in reset while loading.
- busy  output  1  session in progress.
- done  output  1  one-cycle completion pulse.
- checksum  output  32  sum of the words written, mod 2^32.

## Operation

The loader is a four-state machine: IDLE, COLLECT, WRITE and FINISH.

- **IDLE**
  - start=1 latches memory_select and word_count, clears word_index, byte_index and checksum.
  - If word_count=0, go to FINISH. Otherwise go to COLLECT.
- **COLLECT**
  - byte_ready=1.
  - A byte is accepted when byte_valid & byte_ready.
  - Bytes are assembled little-endian: byte 0 goes to bits [7:0] and byte 3 goes to bits [31:24].
  - Acceptance of byte 3 moves the machine to WRITE.
  - byte_valid low simply stalls the machine; there is no timeout.
- **WRITE**
  - For one cycle: write_enable=1, write_address={word_index,2'b00}, write_data=the assembled word. byte_ready=0.
  - checksum += word.
  - word_index increments.
  - If the new word_index equals word_count, go to FINISH. Otherwise return to COLLECT.
- **FINISH**
  - done=1 for exactly one cycle, then return to IDLE.
- **Output rules**
  - busy=1 and processor_hold=1 in COLLECT and WRITE only.
  - start is ignored outside IDLE.
  - write_address, write_data and write_target hold their last values when write_enable=0.
  - checksum holds until the next accepted start.
- **Boundary conditions**
  - word_count=2^ADDRESS_WIDTH fills the whole memory. The last address is (2^ADDRESS_WIDTH−1)*4. word_index never wraps within a session.
  - checksum addition wraps mod 2^32 with no overflow flag.
- **Reset (any state, including mid-word)**
  - All state and outputs go to 0 and the state goes to IDLE.
  - A partial word is discarded and no write is issued.

## Timing

- Reset values: byte_ready=0, write_enable=0, write_target=0, write_address=0, write_data=0, processor_hold=0, busy=0, done=0, checksum=0.
- start accepted at edge N: COLLECT begins in cycle N+1, with byte_ready, busy and processor_hold high.
- Byte 3 accepted at edge M: write_enable is high during cycle M+1, and byte_ready is low in that cycle. COLLECT resumes in cycle M+2. If that write was the last word, FINISH occupies cycle M+2 instead.
- FINISH cycle: done=1, busy=0, processor_hold=0. IDLE follows on the next cycle, and a start can be accepted from then on.
- word_count=0: start at edge N gives done high in cycle N+1 and no write.
- Maximum throughput is one word per 5 cycles.
- The loader produces no combinational path from input to output.

## Test plan

- **Reset:** assert reset low mid-run, including between edges (async). Required: all outputs read 0 immediately; state is IDLE after release.
- **Two-word load to instruction memory:** start with word_count=2, memory_select=0; stream 78 56 34 12 EF BE AD DE back-to-back. Required:
  - write at address 0x0 with data 0x12345678;
  - write at address 0x4 with data 0xDEADBEEF;
  - write_target=0 on both writes;
  - done asserted 1 cycle after the second write;
  - checksum=0xF0E21567.
- **Gaps and stray start:** data-memory load (memory_select=1) with word_count=1, random byte_valid gaps, and a start pulse mid-session. Required:
  - exactly one write, with write_target=1;
  - the stray start is ignored;
  - processor_hold stays high from the first COLLECT cycle through the write cycle.
- **Zero-length load:** start with word_count=0. Required: done in the next cycle; write_enable, busy and processor_hold never assert.
- **Reset mid-word:** assert reset after 2 bytes of word 0 have been accepted. Required:
  - no write_enable;
  - a fresh 1-word load afterwards writes the correct data to address 0.
- **Full fill and checksum wrap:** word_count=64 with all words 0xFFFFFFFF. Required:
  - last write_address=0xFC;
  - 64 writes exactly;
  - checksum=0xFFFFFFC0 (wrapped);
  - done asserted once.
